pwm_gen_periph: RTL and testbench

- Memory-mapped PWM generator on the openMSP430 peripheral bus.
- Drives the PWM_out strobe consumed by the ring-oscillator measurement block, which gates RO enable and count capture with it.
- Software programs period, duty and an optional burst length.
- The block runs a free-running or burst-limited PWM and reports run/done status.

---
 rtl/pwm_gen_pkg.sv | 29 ++
 rtl/pwm_gen_core.sv | 137 +++++++++++++
 rtl/pwm_gen_periph.sv | 126 ++++++++++++
 tb/tb_pwm_gen_periph.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_gen_pkg.sv
// pwm_gen_pkg: shared constants and types for the PWM generator peripheral.
// Register byte offsets, CTRL/STATUS bit positions and the FSM state type.
package pwm_gen_pkg;

  // Register byte offsets relative to BASE_ADDR
  localparam int unsigned OFS_CTRL   = 0;
  localparam int unsigned OFS_PERIOD = 2;
  localparam int unsigned OFS_DUTY   = 4;
  localparam int unsigned OFS_BURST  = 6;
  localparam int unsigned OFS_STATUS = 8;
  localparam int unsigned OFS_COUNT  = 10;

  // CTRL bit positions
  localparam int unsigned CTRL_EN_BIT     = 0;
  localparam int unsigned CTRL_BURST_BIT  = 1;
  localparam int unsigned CTRL_INV_BIT    = 2;
  localparam int unsigned CTRL_IRQ_EN_BIT = 3;

  // STATUS bit positions
  localparam int unsigned STAT_RUN_BIT  = 0;
  localparam int unsigned STAT_DONE_BIT = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } pwm_state_t;

endpackage

// File: rtl/pwm_gen_core.sv
// pwm_gen_core: PWM sequencing engine.
// Holds the IDLE/RUN/DONE FSM, the cycle counter, the period counter used in
// burst mode, the active period/duty copies and the registered PWM output.
module pwm_gen_core
  import pwm_gen_pkg::*;
#(
  parameter int unsigned CW = 16
) (
  input  logic          mclk,
  input  logic          puc_rst,
  input  logic          ctrl_en,
  input  logic          ctrl_burst,
  input  logic          ctrl_inv,
  input  logic          ctrl_wr,
  input  logic          ctrl_wr_en,
  input  logic [CW-1:0] period,
  input  logic [CW-1:0] duty,
  input  logic [CW-1:0] burst,
  output logic [CW-1:0] cnt,
  output logic          running,
  output logic          done_set,
  output logic          PWM_out
);

  pwm_state_t    state_q;
  pwm_state_t    state_nxt;
  logic [CW-1:0] cnt_nxt;
  logic [CW-1:0] pcount_q;
  logic [CW-1:0] pcount_nxt;
  logic [CW-1:0] per_act;
  logic [CW-1:0] duty_act;
  logic [CW-1:0] burst_eff;
  logic          ctrl_wr_q;
  logic          period_end;
  logic          burst_end;
  logic          load_act;

  // A burst length of zero behaves as a single period
  assign burst_eff  = (burst == '0) ? CW'(1) : burst;
  assign period_end = (state_q == RUN) && (cnt == per_act);
  assign burst_end  = ctrl_burst && ((pcount_q + CW'(1)) == burst_eff);
  assign load_act   = (state_q != RUN) || period_end;
  assign running    = (state_q == RUN);

  // Next-state, counter and burst-completion logic
  always_comb begin
    state_nxt  = state_q;
    cnt_nxt    = cnt;
    pcount_nxt = pcount_q;
    done_set   = 1'b0;
    if (!ctrl_en) begin
      state_nxt  = IDLE;
      cnt_nxt    = '0;
      pcount_nxt = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_nxt  = RUN;
          cnt_nxt    = '0;
          pcount_nxt = '0;
        end
        RUN: begin
          if (period_end) begin
            cnt_nxt = '0;
            if (burst_end) begin
              pcount_nxt = '0;
              // A CTRL write landing on the burst end decides the next state
              // itself, so DONE is neither entered nor flagged.
              if (ctrl_wr) begin
                state_nxt = ctrl_wr_en ? RUN : IDLE;
              end else begin
                state_nxt = DONE;
                done_set  = 1'b1;
              end
            end else begin
              pcount_nxt = pcount_q + CW'(1);
            end
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        DONE: begin
          // Restart uses the registered write strobe so it sees the new EN
          // value and has the same start latency as leaving IDLE.
          if (ctrl_wr_q) begin
            state_nxt  = RUN;
            cnt_nxt    = '0;
            pcount_nxt = '0;
          end
        end
        default: begin
          state_nxt  = IDLE;
          cnt_nxt    = '0;
          pcount_nxt = '0;
        end
      endcase
    end
  end

  // State, counters and CTRL write strobe registers
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      state_q   <= IDLE;
      cnt       <= '0;
      pcount_q  <= '0;
      ctrl_wr_q <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      cnt       <= cnt_nxt;
      pcount_q  <= pcount_nxt;
      ctrl_wr_q <= ctrl_wr;
    end
  end

  // Active period/duty copies, refreshed only at period boundaries or when idle
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      per_act  <= '0;
      duty_act <= '0;
    end else if (load_act) begin
      per_act  <= period;
      duty_act <= duty;
    end
  end

  // Registered PWM strobe; outside RUN it rests at the inversion level
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      PWM_out <= 1'b0;
    end else if (state_q == RUN) begin
      PWM_out <= (cnt < duty_act) ^ ctrl_inv;
    end else begin
      PWM_out <= ctrl_inv;
    end
  end

endmodule

// File: rtl/pwm_gen_periph.sv
// pwm_gen_periph: memory-mapped PWM generator on the openMSP430 peripheral bus.
// Bus decoder, CTRL/PERIOD/DUTY/BURST/STATUS registers and read mux; the
// sequencing lives in pwm_gen_core.
// Optional macro PWM_GEN_IRQ_EN adds the irq_pwm port and the CTRL.IRQ_EN bit.
module pwm_gen_periph
  import pwm_gen_pkg::*;
#(
  parameter logic [14:0] BASE_ADDR = 15'h01C0,
  parameter int unsigned DEC_WD    = 4,
  parameter int unsigned CW        = 16
) (
  input  logic          mclk,
  input  logic          puc_rst,
  input  logic [13:0]   per_addr,
  input  logic [15:0]   per_din,
  input  logic          per_en,
  input  logic [1:0]    per_we,
  output logic [15:0]   per_dout,
  output logic          PWM_out
`ifdef PWM_GEN_IRQ_EN
  ,
  output logic          irq_pwm
`endif
);

`ifdef PWM_GEN_IRQ_EN
  localparam logic [3:0] CTRL_MASK = 4'hF;
`else
  localparam logic [3:0] CTRL_MASK = 4'h7;
`endif

  logic              reg_sel;
  logic              reg_wr;
  logic [DEC_WD-1:0] reg_ofs;
  logic              wr_ctrl;
  logic              wr_period;
  logic              wr_duty;
  logic              wr_burst;
  logic              wr_status;
  logic              status_w1c;

  logic [3:0]        ctrl_q;
  logic [CW-1:0]     period_q;
  logic [CW-1:0]     duty_q;
  logic [CW-1:0]     burst_q;
  logic              status_done_q;

  logic [CW-1:0]     cnt;
  logic              running;
  logic              done_set;

  assign reg_sel = per_en & (per_addr[13:DEC_WD-1] == BASE_ADDR[14:DEC_WD]);
  assign reg_wr  = reg_sel & (|per_we);
  assign reg_ofs = {per_addr[DEC_WD-2:0], 1'b0};

  assign wr_ctrl    = reg_wr && (reg_ofs == DEC_WD'(OFS_CTRL));
  assign wr_period  = reg_wr && (reg_ofs == DEC_WD'(OFS_PERIOD));
  assign wr_duty    = reg_wr && (reg_ofs == DEC_WD'(OFS_DUTY));
  assign wr_burst   = reg_wr && (reg_ofs == DEC_WD'(OFS_BURST));
  assign wr_status  = reg_wr && (reg_ofs == DEC_WD'(OFS_STATUS));
  assign status_w1c = wr_status & per_din[STAT_DONE_BIT];

  // Software-writable configuration registers
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      ctrl_q   <= '0;
      period_q <= '0;
      duty_q   <= '0;
      burst_q  <= '0;
    end else begin
      if (wr_ctrl)   ctrl_q   <= per_din[3:0] & CTRL_MASK;
      if (wr_period) period_q <= per_din;
      if (wr_duty)   duty_q   <= per_din;
      if (wr_burst)  burst_q  <= per_din;
    end
  end

  // Sticky DONE flag; a same-cycle set beats the write-1-to-clear
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      status_done_q <= 1'b0;
    end else begin
      status_done_q <= done_set | (status_done_q & ~status_w1c);
    end
  end

  pwm_gen_core #(
    .CW (CW)
  ) u_core (
    .mclk       (mclk),
    .puc_rst    (puc_rst),
    .ctrl_en    (ctrl_q[CTRL_EN_BIT]),
    .ctrl_burst (ctrl_q[CTRL_BURST_BIT]),
    .ctrl_inv   (ctrl_q[CTRL_INV_BIT]),
    .ctrl_wr    (wr_ctrl),
    .ctrl_wr_en (per_din[CTRL_EN_BIT]),
    .period     (period_q),
    .duty       (duty_q),
    .burst      (burst_q),
    .cnt        (cnt),
    .running    (running),
    .done_set   (done_set),
    .PWM_out    (PWM_out)
  );

`ifdef PWM_GEN_IRQ_EN
  assign irq_pwm = status_done_q & ctrl_q[CTRL_IRQ_EN_BIT];
`endif

  // Combinational read mux, zero when the block is not addressed
  always_comb begin
    per_dout = '0;
    if (reg_sel) begin
      case (reg_ofs)
        DEC_WD'(OFS_CTRL):   per_dout = {{(CW-4){1'b0}}, ctrl_q};
        DEC_WD'(OFS_PERIOD): per_dout = period_q;
        DEC_WD'(OFS_DUTY):   per_dout = duty_q;
        DEC_WD'(OFS_BURST):  per_dout = burst_q;
        DEC_WD'(OFS_STATUS): per_dout = {{(CW-2){1'b0}}, status_done_q, running};
        DEC_WD'(OFS_COUNT):  per_dout = cnt;
        default:             per_dout = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_gen_periph.sv
// tb_pwm_gen_periph: self-checking bench for pwm_gen_periph.
// Table of PWM configurations with expected high-cycle counts and final
// STATUS, randomized runs against an arithmetic PWM model, and hand-written
// sequences for reset, abort, shadow update and same-cycle collisions.
module tb_pwm_gen_periph;

  localparam logic [3:0] R_CTRL   = 4'h0;
  localparam logic [3:0] R_PERIOD = 4'h2;
  localparam logic [3:0] R_DUTY   = 4'h4;
  localparam logic [3:0] R_BURST  = 4'h6;
  localparam logic [3:0] R_STATUS = 4'h8;
  localparam logic [3:0] R_COUNT  = 4'hA;
  localparam int WIN = 40;

  logic        mclk = 1'b0;
  logic        puc_rst;
  logic [13:0] per_addr;
  logic [15:0] per_din;
  logic        per_en;
  logic [1:0]  per_we;
  logic [15:0] per_dout;
  logic        PWM_out;
`ifdef PWM_GEN_IRQ_EN
  logic        irq_pwm;
`endif

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  pwm_gen_periph #(
    .BASE_ADDR (15'h01C0),
    .DEC_WD    (4),
    .CW        (16)
  ) dut (
    .mclk     (mclk),
    .puc_rst  (puc_rst),
    .per_addr (per_addr),
    .per_din  (per_din),
    .per_en   (per_en),
    .per_we   (per_we),
    .per_dout (per_dout),
    .PWM_out  (PWM_out)
`ifdef PWM_GEN_IRQ_EN
    ,
    .irq_pwm  (irq_pwm)
`endif
  );

  always #5 mclk = ~mclk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [15:0] period;
    logic [15:0] duty;
    logic [15:0] burst;
    logic [3:0]  ctrl;
    int          exp_high;
    logic [15:0] exp_status;
  } vec_t;

  vec_t tbl [11];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [13:0] addr_of(input logic [3:0] ofs);
    return 14'h00E0 + 14'(ofs >> 1);
  endfunction

  task automatic drive_wr(input logic [13:0] addr, input logic [15:0] d);
    per_addr = addr;
    per_din  = d;
    per_en   = 1'b1;
    per_we   = 2'b11;
  endtask

  task automatic drive_idle();
    per_en = 1'b0;
    per_we = 2'b00;
  endtask

  // Write is captured at the posedge between the two negedges
  task automatic bus_wr_raw(input logic [13:0] addr, input logic [15:0] d);
    @(negedge mclk);
    drive_wr(addr, d);
    @(negedge mclk);
    drive_idle();
  endtask

  task automatic bus_wr(input logic [3:0] ofs, input logic [15:0] d);
    bus_wr_raw(addr_of(ofs), d);
  endtask

  // Combinational read within the low clock phase
  task automatic bus_rd(input logic [3:0] ofs, output logic [15:0] d);
    per_addr = addr_of(ofs);
    per_we   = 2'b00;
    per_en   = 1'b1;
    #1;
    d = per_dout;
    per_en = 1'b0;
  endtask

  task automatic stop_all();
    bus_wr(R_CTRL, 16'h0000);
    bus_wr(R_STATUS, 16'h0002);
    repeat (2) @(negedge mclk);
  endtask

  // PWM level k cycles after the first active output cycle
  function automatic logic model_pwm(input int p, input int d, input int b,
                                     input logic bm, input logic inv, input int k);
    int plen;
    int beff;
    plen = p + 1;
    beff = (b == 0) ? 1 : b;
    if (bm && (k >= plen * beff)) return inv;
    return ((k % plen) < d) ^ inv;
  endfunction

  task automatic run_window(input vec_t v, output int highs);
    bus_wr(R_PERIOD, v.period);
    bus_wr(R_DUTY, v.duty);
    bus_wr(R_BURST, v.burst);
    bus_wr(R_CTRL, {12'h000, v.ctrl});
    highs = 0;
    for (int j = 1; j <= WIN + 1; j++) begin
      @(negedge mclk);
      if (j >= 2 && PWM_out === 1'b1) highs++;
    end
  endtask

  task automatic random_trial(input int idx);
    int p, d, b, plen, beff, len, ci;
    logic bm, inv, in_run, done;
    logic [15:0] rd;
    p   = int'($urandom_range(0, 11));
    d   = int'($urandom_range(0, 14));
    b   = int'($urandom_range(0, 4));
    bm  = 1'($urandom_range(0, 1));
    inv = 1'($urandom_range(0, 1));
    plen = p + 1;
    beff = (b == 0) ? 1 : b;
    len  = plen * beff;
    stop_all();
    bus_wr(R_PERIOD, 16'(p));
    bus_wr(R_DUTY, 16'(d));
    bus_wr(R_BURST, 16'(b));
    bus_wr(R_CTRL, {13'h0000, inv, bm, 1'b1});
    for (int j = 1; j <= WIN; j++) begin
      @(negedge mclk);
      ci     = j - 1;
      in_run = !bm || (ci < len);
      done   = bm && (ci >= len);
      check($sformatf("rnd%0d_pwm_j%0d", idx, j), {15'h0, PWM_out},
            {15'h0, (j == 1) ? inv : model_pwm(p, d, b, bm, inv, j - 2)});
      bus_rd(R_COUNT, rd);
      check($sformatf("rnd%0d_count_j%0d", idx, j), rd, in_run ? 16'(ci % plen) : 16'h0);
      bus_rd(R_STATUS, rd);
      check($sformatf("rnd%0d_status_j%0d", idx, j), rd, {14'h0, done, in_run});
    end
  endtask

  initial begin
    logic [15:0] rd;
    int h, h0, h1;

    tbl[0]  = '{16'd9,     16'd3,  16'd0, 4'h1, 12, 16'h1};
    tbl[1]  = '{16'd9,     16'd0,  16'd0, 4'h1, 0,  16'h1};
    tbl[2]  = '{16'd9,     16'd20, 16'd0, 4'h1, 40, 16'h1};
    tbl[3]  = '{16'd0,     16'd1,  16'd0, 4'h1, 40, 16'h1};
    tbl[4]  = '{16'd9,     16'd3,  16'd0, 4'h5, 28, 16'h1};
    tbl[5]  = '{16'd4,     16'd2,  16'd3, 4'h3, 6,  16'h2};
    tbl[6]  = '{16'd4,     16'd2,  16'd0, 4'h3, 2,  16'h2};
    tbl[7]  = '{16'd7,     16'd8,  16'd0, 4'h1, 40, 16'h1};
    tbl[8]  = '{16'd7,     16'd7,  16'd0, 4'h1, 35, 16'h1};
    tbl[9]  = '{16'd4,     16'd2,  16'd2, 4'h7, 36, 16'h2};
    tbl[10] = '{16'hFFFF,  16'd5,  16'd0, 4'h1, 5,  16'h1};

    puc_rst  = 1'b1;
    per_addr = '0;
    per_din  = '0;
    per_en   = 1'b0;
    per_we   = 2'b00;
    repeat (3) @(negedge mclk);
    check("rst_pwm", {15'h0, PWM_out}, 16'h0);
    check("rst_dout_unsel", per_dout, 16'h0);
`ifdef PWM_GEN_IRQ_EN
    check("rst_irq", {15'h0, irq_pwm}, 16'h0);
`endif
    puc_rst = 1'b0;
    @(negedge mclk);
    for (int r = 0; r <= 10; r += 2) begin
      bus_rd(4'(r), rd);
      check($sformatf("rst_reg_%0h", r), rd, 16'h0);
    end

    // Register readback, ignored/unmapped writes, decode
    bus_wr(R_PERIOD, 16'hA5A5); bus_rd(R_PERIOD, rd); check("rb_period", rd, 16'hA5A5);
    bus_wr(R_DUTY, 16'h5A5A);   bus_rd(R_DUTY, rd);   check("rb_duty", rd, 16'h5A5A);
    bus_wr(R_BURST, 16'h0F0F);  bus_rd(R_BURST, rd);  check("rb_burst", rd, 16'h0F0F);
    bus_wr(R_COUNT, 16'h0055);  bus_rd(R_COUNT, rd);  check("count_ro", rd, 16'h0);
    bus_wr(4'hC, 16'hFFFF);     bus_rd(4'hC, rd);     check("unmapped_c", rd, 16'h0);
    bus_wr_raw(14'h00F1, 16'h1234);
    bus_rd(R_PERIOD, rd); check("foreign_wr", rd, 16'hA5A5);
    per_addr = 14'h00F1; per_en = 1'b1; #1;
    check("foreign_rd", per_dout, 16'h0);
    per_en = 1'b0;
    bus_wr(R_CTRL, 16'h000F); bus_rd(R_CTRL, rd);
`ifdef PWM_GEN_IRQ_EN
    check("ctrl_mask", rd, 16'h000F);
`else
    check("ctrl_mask", rd, 16'h0007);
`endif
    stop_all();

    // Table-driven configurations
    for (int i = 0; i < 11; i++) begin
      stop_all();
      run_window(tbl[i], h);
      check($sformatf("tbl%0d_highs", i), 16'(h), 16'(tbl[i].exp_high));
      bus_rd(R_STATUS, rd);
      check($sformatf("tbl%0d_status", i), rd, tbl[i].exp_status);
      bus_wr(R_CTRL, 16'h0);
      bus_wr(R_STATUS, 16'h2);
      bus_rd(R_STATUS, rd);
      check($sformatf("tbl%0d_w1c", i), rd, 16'h0);
    end

    // Randomized runs against the arithmetic model
    for (int t = 0; t < 8; t++) random_trial(t);

    // Shadow DUTY update mid-period takes effect at the next period
    stop_all();
    bus_wr(R_PERIOD, 16'd9); bus_wr(R_DUTY, 16'd3); bus_wr(R_BURST, 16'd0);
    bus_wr(R_CTRL, 16'h1);
    h0 = 0; h1 = 0;
    for (int j = 1; j <= 22; j++) begin
      @(negedge mclk);
      if (j >= 2 && j <= 11 && PWM_out === 1'b1) h0++;
      if (j >= 12 && j <= 21 && PWM_out === 1'b1) h1++;
      if (j == 5) drive_wr(addr_of(R_DUTY), 16'd6);
      if (j == 6) drive_idle();
    end
    check("shadow_p0_highs", 16'(h0), 16'd3);
    check("shadow_p1_highs", 16'(h1), 16'd6);

    // Abort: EN=0 in RUN with INV=1
    stop_all();
    bus_wr(R_DUTY, 16'd3);
    bus_wr(R_CTRL, 16'h5);
    repeat (4) @(negedge mclk);
    bus_wr(R_CTRL, 16'h4);
    @(negedge mclk);
    bus_rd(R_STATUS, rd); check("abort_status", rd, 16'h0);
    bus_rd(R_COUNT, rd);  check("abort_count", rd, 16'h0);
    @(negedge mclk);
    check("abort_pwm_inv", {15'h0, PWM_out}, 16'h1);

    // DONE set and W1C in the same cycle: set wins
    stop_all();
    bus_wr(R_PERIOD, 16'd4); bus_wr(R_DUTY, 16'd2); bus_wr(R_BURST, 16'd1);
    bus_wr(R_CTRL, 16'h3);
    for (int j = 1; j <= 8; j++) begin
      @(negedge mclk);
      if (j == 5) drive_wr(addr_of(R_STATUS), 16'h2);
      if (j == 6) drive_idle();
    end
    bus_rd(R_STATUS, rd); check("done_vs_w1c", rd, 16'h2);
    bus_wr(R_STATUS, 16'h2);
    bus_rd(R_STATUS, rd); check("done_w1c_after", rd, 16'h0);

    // CTRL write (EN=0) on the burst-end cycle: write wins, no DONE
    stop_all();
    bus_wr(R_CTRL, 16'h3);
    for (int j = 1; j <= 8; j++) begin
      @(negedge mclk);
      if (j == 5) drive_wr(addr_of(R_CTRL), 16'h0);
      if (j == 6) drive_idle();
    end
    bus_rd(R_STATUS, rd); check("ctrl_vs_burst_end", rd, 16'h0);

`ifdef PWM_GEN_IRQ_EN
    // Burst-done interrupt follows DONE and clears on W1C
    stop_all();
    bus_wr(R_PERIOD, 16'd2); bus_wr(R_DUTY, 16'd1); bus_wr(R_BURST, 16'd1);
    bus_wr(R_CTRL, 16'hB);
    @(negedge mclk);
    check("irq_before_done", {15'h0, irq_pwm}, 16'h0);
    repeat (8) @(negedge mclk);
    check("irq_at_done", {15'h0, irq_pwm}, 16'h1);
    bus_wr(R_STATUS, 16'h2);
    check("irq_after_w1c", {15'h0, irq_pwm}, 16'h0);
`endif

    // Reset mid-burst clears output immediately and all registers
    stop_all();
    bus_wr(R_PERIOD, 16'd9); bus_wr(R_DUTY, 16'd9); bus_wr(R_BURST, 16'd5);
    bus_wr(R_CTRL, 16'h3);
    repeat (3) @(negedge mclk);
    check("pre_rst_pwm", {15'h0, PWM_out}, 16'h1);
    #2 puc_rst = 1'b1;
    #1 check("rst_async_pwm", {15'h0, PWM_out}, 16'h0);
    @(negedge mclk);
    puc_rst = 1'b0;
    for (int r = 0; r <= 10; r += 2) begin
      bus_rd(4'(r), rd);
      check($sformatf("rst2_reg_%0h", r), rd, 16'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
